// File: rtl/sobel_pkg.sv
// Shared types and sizing helpers for the Sobel window sequencing logic.
package sobel_pkg;

    // Window FSM: IDLE until the first pixel, FILL while rows 0..1 load, RUN once windows exist.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } win_state_t;

    // Counter width for a range 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int COLS_DEF  = 640;
    localparam int ROWS_DEF  = 480;
    localparam int COL_W_DEF = cnt_w(COLS_DEF);
    localparam int ROW_W_DEF = cnt_w(ROWS_DEF);

endpackage

// File: rtl/sobel_window_ctrl_cnt.sv
// Wrapping position counter. pos_o is the position of the element being
// accepted this cycle: a clear (frame resync) forces it to zero.
module sobel_window_ctrl_cnt #(
    parameter int MAX_VAL_P = 3,
    parameter int W         = 2
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] pos_o,
    output logic         last_o
);

    assign pos_o  = clr_i ? '0 : cnt_o;
    assign last_o = (pos_o == W'(MAX_VAL_P));

    // Advance from the effective position; a clear without advance parks at zero.
    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            cnt_o <= '0;
        else if (en_i)
            cnt_o <= last_o ? '0 : pos_o + W'(1);
        else if (clr_i)
            cnt_o <= '0;
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster sequencer for the Sobel line-buffer chain: forwards pixels into the
// buffers, tracks column/row, and presents a registered 3x3-window-valid beat.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int WIDTH_P = 8,
    parameter int COLS_P  = 640,
    parameter int ROWS_P  = 480
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [WIDTH_P-1:0]        data_i,
    input  logic                      sof_i,
    output logic                      buf_valid_o,
    input  logic                      buf_ready_i,
    output logic [WIDTH_P-1:0]        buf_data_o,
    output logic                      win_valid_o,
    input  logic                      ready_i,
    output logic [$clog2(COLS_P)-1:0] win_col_o,
    output logic [$clog2(ROWS_P)-1:0] win_row_o,
    output logic                      eof_o,
    output logic                      frame_done_o,
    output logic                      err_o,
    output logic [1:0]                state_o
);

    localparam int COL_W = cnt_w(COLS_P);
    localparam int ROW_W = cnt_w(ROWS_P);

    logic             room;
    logic             fire;
    logic             sof_fire;
    logic             win_fire;
    logic             frame_last;
    logic [COL_W-1:0] col, col_pos;
    logic [ROW_W-1:0] row, row_pos;
    logic             col_last, row_last;
    win_state_t       state, state_nxt;

    // A new pixel may enter only if the window register can take its result.
    assign room        = ~win_valid_o | ready_i;
    assign ready_o     = buf_ready_i & room;
    assign buf_valid_o = valid_i & room;
    assign buf_data_o  = data_i;
    assign fire        = valid_i & ready_o;
    assign sof_fire    = fire & sof_i;

    sobel_window_ctrl_cnt #(.MAX_VAL_P(COLS_P - 1), .W(COL_W)) u_col (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (sof_fire),
        .en_i   (fire),
        .cnt_o  (col),
        .pos_o  (col_pos),
        .last_o (col_last)
    );

    sobel_window_ctrl_cnt #(.MAX_VAL_P(ROWS_P - 1), .W(ROW_W)) u_row (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (sof_fire),
        .en_i   (fire & col_last),
        .cnt_o  (row),
        .pos_o  (row_pos),
        .last_o (row_last)
    );

    assign win_fire   = fire & (row_pos >= ROW_W'(2)) & (col_pos >= COL_W'(2));
    assign frame_last = fire & row_last & col_last;

    // ---- window register: one cycle after the qualifying fire, aligned to buffer read data ----
    // Window beat: load on a new window, otherwise hold until the kernel consumes it.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            win_valid_o <= 1'b0;
            eof_o       <= 1'b0;
            win_col_o   <= '0;
            win_row_o   <= '0;
        end else if (win_fire) begin
            win_valid_o <= 1'b1;
            eof_o       <= row_last & col_last;
            win_col_o   <= col_pos - COL_W'(1);
            win_row_o   <= row_pos - ROW_W'(1);
        end else if (ready_i) begin
            win_valid_o <= 1'b0;
            eof_o       <= 1'b0;
        end
    end

    // Frame-done pulse and sticky error for a start-of-frame landing off the origin.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            frame_done_o <= frame_last;
            if (sof_fire && (col != '0 || row != '0))
                err_o <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: a resync in RUN drops back to FILL since the pixel becomes row 0.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fire) state_nxt = FILL;
            FILL: if (fire && !sof_i && col_last && row_pos == ROW_W'(1)) state_nxt = RUN;
            RUN:  if (sof_fire || frame_last) state_nxt = FILL;
            default: state_nxt = IDLE;
        endcase
    end

    assign state_o = state;

endmodule
